// File: rtl/pwm_meter.sv
//------------------------------------------------------------------------------
// Module   : pwm_meter
// Measures the period, high time and duty of an asynchronous PWM/tone input.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_meter #(
  parameter logic [31:0] TIMEOUT   = 32'd2_000_000,
  parameter int          DUTY_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [31:0]          period_o,
  output logic [31:0]          high_o,
  output logic [DUTY_BITS-1:0] duty_o,
  output logic                 valid,
  output logic                 silent
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEAS_HIGH  = 2'd1,
    MEAS_LOW   = 2'd2
  } state_t;

  localparam logic [3:0] c_last_step = 4'(DUTY_BITS - 1);

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_s;
  logic                 r_s_d;
  logic [31:0]          r_cnt;
  logic [31:0]          r_high_c;
  logic                 r_busy;
  logic [3:0]           r_step;
  logic [31:0]          r_div_period;
  logic [31:0]          r_div_high;
  logic [31:0]          r_rem;
  logic [DUTY_BITS-1:0] r_quot;

  logic                 w_rise;
  logic                 w_fall;
  logic [31:0]          w_cnt_inc;
  logic                 w_timeout;
  logic [32:0]          w_rem2;
  logic                 w_ge;
  logic [31:0]          w_rem_next;
  logic [DUTY_BITS-1:0] w_quot_next;

  assign w_rise    = r_s & ~r_s_d;
  assign w_fall    = ~r_s & r_s_d;
  // Post-increment count: the number of cycles elapsed since the last rising edge.
  assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
  assign w_timeout = (r_state != WAIT_FIRST) && !w_rise && (w_cnt_inc >= TIMEOUT);

  // Restoring divide step; the true remainder is below the divisor, so 32-bit wrap is exact.
  assign w_rem2      = {r_rem, 1'b0};
  assign w_ge        = w_rem2 >= {1'b0, r_div_period};
  assign w_rem_next  = w_ge ? (w_rem2[31:0] - r_div_period) : w_rem2[31:0];
  assign w_quot_next = {r_quot[DUTY_BITS-2:0], w_ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= WAIT_FIRST;
      r_sync1      <= 1'b0;
      r_s          <= 1'b0;
      r_s_d        <= 1'b0;
      r_cnt        <= 32'd0;
      r_high_c     <= 32'd0;
      r_busy       <= 1'b0;
      r_step       <= 4'd0;
      r_div_period <= 32'd0;
      r_div_high   <= 32'd0;
      r_rem        <= 32'd0;
      r_quot       <= '0;
      period_o     <= 32'd0;
      high_o       <= 32'd0;
      duty_o       <= '0;
      valid        <= 1'b0;
      silent       <= 1'b1;
    end else begin
      r_sync1 <= pwm_in;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
      valid   <= 1'b0;
      r_cnt   <= w_rise ? 32'd0 : w_cnt_inc;

      if (w_timeout) begin
        r_state  <= WAIT_FIRST;
        r_busy   <= 1'b0;
        period_o <= 32'd0;
        high_o   <= 32'd0;
        duty_o   <= '0;
        silent   <= 1'b1;
      end else begin
        case (r_state)
          WAIT_FIRST: begin
            if (w_rise) r_state <= MEAS_HIGH;
          end
          MEAS_HIGH: begin
            if (w_fall) begin
              r_high_c <= w_cnt_inc;
              r_state  <= MEAS_LOW;
            end
          end
          MEAS_LOW: begin
            if (w_rise) begin
              r_state <= MEAS_HIGH;
              // A period closing while the divider is still working is dropped.
              if (!r_busy) begin
                r_div_period <= w_cnt_inc;
                r_div_high   <= r_high_c;
                r_rem        <= r_high_c;
                r_quot       <= '0;
                r_step       <= 4'd0;
                r_busy       <= 1'b1;
              end
            end
          end
          default: r_state <= WAIT_FIRST;
        endcase

        if (r_busy) begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_step <= r_step + 4'd1;
          if (r_step == c_last_step) begin
            r_busy   <= 1'b0;
            period_o <= r_div_period;
            high_o   <= r_div_high;
            duty_o   <= w_quot_next;
            valid    <= 1'b1;
            silent   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/pwm_meter.md
PWM_METER -- requirements
Module: pwm_meter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd2_000_000, meaning clk cycles without a rising edge before the input is declared silent.
REQ-002 SHALL have parameter DUTY_BITS, default 10, meaning duty result width (fixed at 10; other values unsupported).
REQ-003 clk  input  1  system clock, all state on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 pwm_in  input  1  square/PWM tone under measurement, asynchronous to clk, same signalling as the speaker pmod_1 output.
REQ-006 period_o  output  32  last reported period in clk cycles.
REQ-007 high_o  output  32  last reported high time in clk cycles.
REQ-008 duty_o  output  10  last reported duty, high_o*1024/period_o, truncated.
REQ-009 valid  output  1  one-cycle pulse when period_o/high_o/duty_o update.
REQ-010 silent  output  1  level, high while no tone is present.

Function
REQ-011 SHALL pass pwm_in through a 2-flop synchronizer (s); edge detect compares s with its 1-cycle delayed copy s_d.
REQ-012 Rising edge: s=1,s_d=0; falling edge: s=0,s_d=1; detection cycle is the edge cycle.
REQ-013 SHALL keep 32-bit counter cnt: loads 0 in a rising-edge cycle, else increments, saturating at 32'hFFFF_FFFF.
REQ-014 States: WAIT_FIRST, MEAS_HIGH, MEAS_LOW; divider BUSY flag independent of state.
REQ-015 WAIT_FIRST: falling edges ignored; rising edge -> MEAS_HIGH (arms only, no result).
REQ-016 MEAS_HIGH: falling edge latches high_c=cnt -> MEAS_LOW (5 high cycles gives high_c=5).
REQ-017 MEAS_LOW: rising edge at cycle T latches period_c=cnt -> MEAS_HIGH; if divider idle, starts divide.
REQ-018 Closing rising edge while divider busy SHALL discard that period (no result); counting still restarts at that edge.
REQ-019 Divider: sequential restoring, 10 iterations in cycles T+1..T+10; r starts at high_c; each step r=2r, if r>=period_c then r-=period_c, quotient bit=1 (MSB first); compare width 33 bits.
REQ-020 In cycle T+11: period_o=period_c, high_o=high_c, duty_o=quotient, valid=1 for that single cycle, silent=0.
REQ-021 high_c<period_c always, so duty_o<=1023; no saturation needed.
REQ-022 Timeout: cnt reaching TIMEOUT in any state other than WAIT_FIRST -> WAIT_FIRST, silent=1, period_o/high_o/duty_o=0, divider aborted without valid.
REQ-023 Input stuck high or low SHALL both resolve via REQ-022; silent stays 1 until the next valid.
REQ-024 Edge and timeout in same cycle: edge wins, cnt loads 0.

Reset
REQ-025 rst=0 SHALL immediately force: state WAIT_FIRST, cnt=0, synchronizer flops=0, divider idle, period_o=0, high_o=0, duty_o=0, valid=0, silent=1.
REQ-026 Reset asserted mid-measurement or mid-divide SHALL discard it; no valid after release until a full new period is measured.
REQ-027 After release, the first rising edge only arms; earliest valid is 11 cycles after the second rising edge.

Verification
REQ-028 Reset: rst=0 -> all data outputs 0, valid=0, silent=1; release, pwm_in=0 -> unchanged.
REQ-029 pwm_in 50 high/50 low repeating -> valid every 100 cycles after the second edge, period_o=100, high_o=50, duty_o=512, silent=0.
REQ-030 25 high/75 low -> period_o=100, high_o=25, duty_o=256; 1 high/99 low -> duty_o=10.
REQ-031 5 high/5 low (period < divide time) -> valid every 20 cycles, period_o=10, high_o=5, duty_o=512; alternate periods discarded.
REQ-032 TIMEOUT=1000, tone then pwm_in held low -> silent=1 and outputs 0 exactly when cnt reaches 1000; held high gives same result.
REQ-033 rst pulsed low during divide cycles T+1..T+10 -> no valid, outputs 0, silent=1; tone resumes -> normal valid at 11 cycles after the second edge.
